// File: rtl/acq_pkg.sv
// Shared types and helpers for the acquisition sequencer.
package acq_pkg;

  localparam int TRIG_W = 10;
  localparam int LEN_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRETRIG  = 3'd1,
    ST_ARMED    = 3'd2,
    ST_POSTTRIG = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // Words still to be captured after the trigger word (the trigger word
  // itself counts as the first). Never less than one.
  function automatic logic [LEN_W-1:0] calc_post_len(input logic [LEN_W-1:0] len,
                                                     input logic [15:0]      pre);
    logic [LEN_W-1:0] pre_ext;
    pre_ext = {16'd0, pre};
    if (len > pre_ext) return len - pre_ext;
    else               return 32'd1;
  endfunction

endpackage

// File: rtl/acq_edge_detect.sv
// Threshold-crossing detector on the trigger channel field.
// After reload the first valid sample only seeds prev_s, so a crossing
// can never be reported against a stale pre-trigger value.
module acq_edge_detect
  import acq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              reload_i,
  input  logic              valid_i,
  input  logic [TRIG_W-1:0] cur_i,
  input  logic [TRIG_W-1:0] thr_i,
  input  logic              rising_i,
  output logic              trig_hit_o
);

  logic [TRIG_W-1:0] prev_q;
  logic              primed_q;
  logic              rise, fall;

  // Edge select against the previously seen sample.
  always_comb begin
    rise       = (prev_q <  thr_i) && (cur_i >= thr_i);
    fall       = (prev_q >= thr_i) && (cur_i <  thr_i);
    trig_hit_o = primed_q && valid_i && (rising_i ? rise : fall);
  end

  // prev_s tracks the last valid sample; reload un-primes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= '0;
      primed_q <= 1'b0;
    end else if (reload_i) begin
      primed_q <= 1'b0;
    end else if (valid_i) begin
      prev_q   <= cur_i;
      primed_q <= 1'b1;
    end
  end

endmodule

// File: rtl/acq_sequencer.sv
// Pre/post-trigger capture sequencer between the LVDS deserializer and
// the sample FIFO write port (clklvds domain).
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int DATA_W      = 140,
  parameter int TRIG_LSB    = 80,
  parameter int USED_W      = 11,
  parameter int FIFO_DEPTH  = 1024,
  parameter int FULL_MARGIN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [15:0]       cfg_pretrig,
  input  logic [31:0]       cfg_length,
  input  logic [9:0]        cfg_threshold,
  input  logic              cfg_rising,
  input  logic              arm,
  input  logic              force_trig,
  input  logic              abort,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [USED_W-1:0] fifo_wrused,
  output logic              fifo_wr,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic              fifo_drop,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [31:0]       trig_pos
);

  localparam logic [USED_W-1:0] ROOM_LIMIT = USED_W'(FIFO_DEPTH - FULL_MARGIN);

  state_e            state_q, state_d;
  logic [15:0]       cfg_pre_q;
  logic [LEN_W-1:0]  cfg_len_q;
  logic [TRIG_W-1:0] cfg_thr_q;
  logic              cfg_rise_q;
  logic [LEN_W-1:0]  wr_count_q, wr_count_d;
  logic [15:0]       pre_cnt_q, pre_cnt_d;
  logic [LEN_W-1:0]  post_cnt_q, post_cnt_d;
  logic              overflow_q, overflow_d;
  logic [LEN_W-1:0]  trig_pos_q, trig_pos_d;
  logic              wr_q, wr_d;
  logic              drop_q, drop_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              in_cap, room, writable, reload, trig_hit;
  logic [LEN_W-1:0]  post_len;

  assign in_cap    = (state_q == ST_PRETRIG) || (state_q == ST_ARMED) || (state_q == ST_POSTTRIG);
  assign room      = fifo_wrused < ROOM_LIMIT;
  assign writable  = sample_valid && room && in_cap;
  assign post_len  = calc_post_len(cfg_len_q, cfg_pre_q);
  assign reload    = (state_d == ST_ARMED) && (state_q != ST_ARMED);

  assign cfg_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy       = in_cap;
  assign done       = (state_q == ST_DONE);
  assign overflow   = overflow_q;
  assign trig_pos   = trig_pos_q;
  assign fifo_wr    = wr_q;
  assign fifo_drop  = drop_q;
  assign fifo_wdata = wdata_q;

  acq_edge_detect u_edge (
    .clk        (clk),
    .rst        (rst),
    .reload_i   (reload),
    .valid_i    (sample_valid),
    .cur_i      (sample_in[TRIG_LSB +: TRIG_W]),
    .thr_i      (cfg_thr_q),
    .rising_i   (cfg_rise_q),
    .trig_hit_o (trig_hit)
  );

  // Configuration is only accepted while no capture is running.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_pre_q  <= '0;
      cfg_len_q  <= '0;
      cfg_thr_q  <= '0;
      cfg_rise_q <= 1'b1;
    end else if (cfg_valid && cfg_ready) begin
      cfg_pre_q  <= cfg_pretrig;
      cfg_len_q  <= cfg_length;
      cfg_thr_q  <= cfg_threshold;
      cfg_rise_q <= cfg_rising;
    end
  end

  // Next-state, counters and the registered FIFO write port.
  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    overflow_d = overflow_q;
    trig_pos_d = trig_pos_q;
    wr_d       = 1'b0;
    drop_d     = 1'b0;
    wdata_d    = wdata_q;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      if (sample_valid && in_cap && !room) overflow_d = 1'b1;
      if (writable) wdata_d = sample_in;

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            wr_count_d = '0;
            pre_cnt_d  = '0;
            post_cnt_d = '0;
            overflow_d = 1'b0;
            state_d    = (cfg_pre_q == 16'd0) ? ST_ARMED : ST_PRETRIG;
          end
        end
        ST_PRETRIG: begin
          if (writable) begin
            wr_d       = 1'b1;
            wr_count_d = wr_count_q + 32'd1;
            pre_cnt_d  = pre_cnt_q + 16'd1;
            if (pre_cnt_d >= cfg_pre_q) state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (writable && (trig_hit || force_trig)) begin
            // Trigger word is kept: no drop on this write.
            wr_d       = 1'b1;
            trig_pos_d = wr_count_q;
            wr_count_d = wr_count_q + 32'd1;
            post_cnt_d = 32'd1;
            state_d    = (post_len == 32'd1) ? ST_DONE : ST_POSTTRIG;
          end else if (force_trig) begin
            // Forced with nothing to write: the next written word is the trigger.
            trig_pos_d = wr_count_q;
            post_cnt_d = '0;
            state_d    = ST_POSTTRIG;
          end else if (writable) begin
            // Circular pre-trigger window: write one, discard the oldest.
            wr_d       = 1'b1;
            drop_d     = (fifo_wrused != '0);
            wr_count_d = wr_count_q + 32'd1;
          end
        end
        ST_POSTTRIG: begin
          if (writable) begin
            wr_d       = 1'b1;
            wr_count_d = wr_count_q + 32'd1;
            post_cnt_d = post_cnt_q + 32'd1;
            if (post_cnt_d >= post_len) state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_count_q <= '0;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
      overflow_q <= 1'b0;
      trig_pos_q <= '0;
      wr_q       <= 1'b0;
      drop_q     <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      overflow_q <= overflow_d;
      trig_pos_q <= trig_pos_d;
      wr_q       <= wr_d;
      drop_q     <= drop_d;
      wdata_q    <= wdata_d;
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: inputs change and outputs are checked
// just after the falling edge; a negedge monitor tallies FIFO activity.
module tb_acq_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid, cfg_ready;
  logic [15:0]  cfg_pretrig;
  logic [31:0]  cfg_length;
  logic [9:0]   cfg_threshold;
  logic         cfg_rising;
  logic         arm, force_trig, abort, sample_valid;
  logic [139:0] sample_in;
  logic [10:0]  fifo_wrused;
  logic         fifo_wr, fifo_drop, busy, done, overflow;
  logic [139:0] fifo_wdata;
  logic [31:0]  trig_pos;

  int checks = 0;
  int failures = 0;

  int       n_wr = 0;
  int       n_drop = 0;
  logic [9:0] wfield[$];
  logic       wdrop[$];

  always #5 clk = ~clk;

  acq_sequencer dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pretrig(cfg_pretrig), .cfg_length(cfg_length),
    .cfg_threshold(cfg_threshold), .cfg_rising(cfg_rising),
    .arm(arm), .force_trig(force_trig), .abort(abort),
    .sample_valid(sample_valid), .sample_in(sample_in),
    .fifo_wrused(fifo_wrused),
    .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .fifo_drop(fifo_drop),
    .busy(busy), .done(done), .overflow(overflow), .trig_pos(trig_pos)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_wr) begin
        n_wr++;
        wfield.push_back(fifo_wdata[89:80]);
        wdrop.push_back(fifo_drop);
      end
      if (fifo_drop) n_drop++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [139:0] mk(input int f);
    logic [139:0] s;
    s = {35{4'hA}};
    s[89:80] = f[9:0];
    s[9:0]   = ~f[9:0];
    return s;
  endfunction

  task automatic configure(input int pre, input int len, input int thr, input logic rising);
    cfg_valid = 1'b1; cfg_pretrig = pre[15:0]; cfg_length = len;
    cfg_threshold = thr[9:0]; cfg_rising = rising;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic send(input int f);
    sample_valid = 1'b1; sample_in = mk(f);
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    int b_wr, b_drop, b_q, bad, snap;
    rst = 1'b1; cfg_valid = 0; cfg_pretrig = 0; cfg_length = 0; cfg_threshold = 0;
    cfg_rising = 0; arm = 0; force_trig = 0; abort = 0; sample_valid = 0;
    sample_in = '0; fifo_wrused = '0;
    tick(); tick();
    chk("rst_fifo_wr", fifo_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_trig_pos", trig_pos, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    rst = 1'b0;
    tick();
    fifo_wrused = 11'd100;

    // 1: rising ramp, pretrig 4, length 10 -> window of 10 words
    configure(4, 10, 512, 1'b1);
    b_wr = n_wr; b_drop = n_drop; b_q = wfield.size();
    do_arm();
    chk("t1_busy_after_arm", busy, 1);
    chk("t1_cfg_ready_busy", cfg_ready, 0);
    for (int i = 0; i < 31; i++) send(500 + i);
    tick();
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_writes", n_wr - b_wr, 18);
    chk("t1_drops", n_drop - b_drop, 8);
    chk("t1_net_depth", (n_wr - b_wr) - (n_drop - b_drop), 10);
    chk("t1_trig_pos", trig_pos, 12);
    chk("t1_trig_word", wfield[b_q + 12], 512);
    bad = 0;
    for (int k = 0; k < 18; k++)
      if (wdrop[b_q + k] !== ((k >= 4) && (k <= 11))) bad++;
    chk("t1_drop_pattern", bad, 0);

    // 2: pretrig 0, length 1, force_trig three cycles after arm
    configure(0, 1, 512, 1'b1);
    b_wr = n_wr; b_drop = n_drop;
    do_arm();
    tick(); tick();
    force_trig = 1'b1;
    send(7);
    force_trig = 1'b0;
    tick();
    chk("t2_writes", n_wr - b_wr, 1);
    chk("t2_drops", n_drop - b_drop, 0);
    chk("t2_done", done, 1);
    chk("t2_trig_pos", trig_pos, 0);

    // 3: FIFO near full during post-trigger stalls the count
    configure(2, 6, 512, 1'b1);
    b_wr = n_wr; b_drop = n_drop;
    do_arm();
    send(0); send(0); send(0); send(600);
    chk("t3_trig_pos", trig_pos, 3);
    chk("t3_overflow_clear", overflow, 0);
    snap = n_wr;
    fifo_wrused = 11'd1020;
    for (int i = 0; i < 5; i++) send(700);
    chk("t3_blocked_no_wr", n_wr - snap, 0);
    chk("t3_overflow_set", overflow, 1);
    chk("t3_still_busy", busy, 1);
    fifo_wrused = 11'd100;
    send(700); send(700);
    chk("t3_not_done_early", done, 0);
    send(700);
    chk("t3_done", done, 1);
    chk("t3_writes", n_wr - b_wr, 7);
    chk("t3_drops", n_drop - b_drop, 1);
    chk("t3_overflow_sticky", overflow, 1);

    // 4: falling mode, first ARMED sample cannot trigger
    configure(2, 8, 100, 1'b0);
    b_wr = n_wr; b_drop = n_drop; b_q = wfield.size();
    do_arm();
    chk("t4_overflow_cleared_by_arm", overflow, 0);
    send(300); send(200); send(50); send(200); send(50);
    chk("t4_trig_pos", trig_pos, 4);
    chk("t4_writes", n_wr - b_wr, 5);
    chk("t4_drops", n_drop - b_drop, 2);
    chk("t4_trig_word", wfield[b_q + 4], 50);
    chk("t4_busy_post", busy, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t4_abort_idle", busy, 0);

    // 5: abort together with a triggering sample
    configure(0, 10, 512, 1'b1);
    b_wr = n_wr;
    do_arm();
    send(0); send(0);
    snap = n_wr;
    abort = 1'b1;
    send(600);
    abort = 1'b0;
    chk("t5_no_wr_on_abort", n_wr - snap, 0);
    chk("t5_fifo_wr_low", fifo_wr, 0);
    chk("t5_idle", busy, 0);
    chk("t5_not_done", done, 0);
    chk("t5_cfg_ready", cfg_ready, 1);
    chk("t5_trig_pos_held", trig_pos, 4);
    chk("t5_writes", n_wr - b_wr, 2);

    // 6: length below pretrig -> single post word
    configure(8, 3, 512, 1'b1);
    b_wr = n_wr; b_drop = n_drop;
    do_arm();
    for (int i = 0; i < 8; i++) send(0);
    chk("t6_armed_not_done", done, 0);
    force_trig = 1'b1;
    send(0);
    force_trig = 1'b0;
    send(0);
    tick();
    chk("t6_writes", n_wr - b_wr, 9);
    chk("t6_drops", n_drop - b_drop, 0);
    chk("t6_trig_pos", trig_pos, 8);
    chk("t6_done", done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
